// File: rtl/issue_sched_pkg.sv
// Shared types and constants for the dual-issue scheduler.
package issue_sched_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        SPLIT  = 1'b1
    } sched_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [2:0] LD_NONE  = 3'b000;

endpackage

// File: rtl/issue_scheduler_lu_hazard.sv
// Load-use hazard of one decode slot against both E-stage slots.
module lu_hazard
    import issue_sched_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int LD_W  = 3
) (
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd_e1,
    input  logic [REG_W-1:0] rd_e2,
    input  logic             reg_write_e1,
    input  logic             reg_write_e2,
    input  logic [LD_W-1:0]  mem_load_e1,
    input  logic [LD_W-1:0]  mem_load_e2,
    output logic             hazard
);

    logic hit_e1;
    logic hit_e2;

    // A producer in E only hazards if it is a real load writing a non-zero register.
    assign hit_e1 = ((rs1 == rd_e1) || (rs2 == rd_e1)) && (rd_e1 != REG_W'(REG_ZERO))
                    && reg_write_e1 && (mem_load_e1 != LD_W'(LD_NONE));
    assign hit_e2 = ((rs1 == rd_e2) || (rs2 == rd_e2)) && (rd_e2 != REG_W'(REG_ZERO))
                    && reg_write_e2 && (mem_load_e2 != LD_W'(LD_NONE));

    assign hazard = hit_e1 || hit_e2;

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue decode sequencer: load-use stalls, intra-pair splitting, E-redirect flush.
// Optional ISSUE_SCHED_PERF_EN adds load-use stall and split event counters.
module issue_scheduler
    import issue_sched_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int LD_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validD1,
    input  logic             validD2,
    input  logic [REG_W-1:0] rs1D1,
    input  logic [REG_W-1:0] rs2D1,
    input  logic [REG_W-1:0] rdD1,
    input  logic [REG_W-1:0] rs1D2,
    input  logic [REG_W-1:0] rs2D2,
    input  logic [REG_W-1:0] rdD2,
    input  logic             reg_writeD1,
    input  logic             memD1,
    input  logic             memD2,
    input  logic [REG_W-1:0] rdE1,
    input  logic [REG_W-1:0] rdE2,
    input  logic             reg_writeE1,
    input  logic             reg_writeE2,
    input  logic [LD_W-1:0]  mem_loadE1,
    input  logic [LD_W-1:0]  mem_loadE2,
    input  logic             flushE,
    output logic             issue1,
    output logic             issue2,
    output logic             stallD,
    output logic             bubbleE,
`ifdef ISSUE_SCHED_PERF_EN
    output logic [31:0]      lu_stall_cnt,
    output logic [31:0]      split_cnt,
`endif
    output logic             split_active
);

    sched_state_t state_q;
    sched_state_t state_d;

    logic lu_slot1;
    logic lu_slot2;
    logic lu_pair;
    logic dep;
    logic memc;
    logic lu_stall;
    logic unused_rd_d2;

    lu_hazard #(.REG_W(REG_W), .LD_W(LD_W)) u_lu_slot1 (
        .rs1          (rs1D1),
        .rs2          (rs2D1),
        .rd_e1        (rdE1),
        .rd_e2        (rdE2),
        .reg_write_e1 (reg_writeE1),
        .reg_write_e2 (reg_writeE2),
        .mem_load_e1  (mem_loadE1),
        .mem_load_e2  (mem_loadE2),
        .hazard       (lu_slot1)
    );

    lu_hazard #(.REG_W(REG_W), .LD_W(LD_W)) u_lu_slot2 (
        .rs1          (rs1D2),
        .rs2          (rs2D2),
        .rd_e1        (rdE1),
        .rd_e2        (rdE2),
        .reg_write_e1 (reg_writeE1),
        .reg_write_e2 (reg_writeE2),
        .mem_load_e1  (mem_loadE1),
        .mem_load_e2  (mem_loadE2),
        .hazard       (lu_slot2)
    );

    // WAW within the pair needs no split: slot 2 simply writes back last.
    assign unused_rd_d2 = ^rdD2;

    assign lu_pair = (validD1 && lu_slot1) || (validD2 && lu_slot2);
    assign dep     = validD2 && reg_writeD1 && (rdD1 != REG_W'(REG_ZERO))
                     && ((rs1D2 == rdD1) || (rs2D2 == rdD1));
    assign memc    = validD1 && validD2 && memD1 && memD2;

    always_comb begin
        state_d  = state_q;
        issue1   = 1'b0;
        issue2   = 1'b0;
        stallD   = 1'b0;
        bubbleE  = 1'b1;
        lu_stall = 1'b0;
        if (reset) begin
            state_d = NORMAL;
        end else if (flushE) begin
            // Redirect wins: any slot 2 still waiting is wrong-path.
            state_d = NORMAL;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (lu_pair) begin
                        stallD   = 1'b1;
                        lu_stall = 1'b1;
                    end else if (dep || memc) begin
                        issue1  = validD1;
                        stallD  = 1'b1;
                        bubbleE = 1'b0;
                        state_d = SPLIT;
                    end else begin
                        issue1  = validD1;
                        issue2  = validD2;
                        bubbleE = !(validD1 || validD2);
                    end
                end
                SPLIT: begin
                    if (lu_slot2) begin
                        stallD   = 1'b1;
                        lu_stall = 1'b1;
                    end else begin
                        issue2  = 1'b1;
                        bubbleE = 1'b0;
                        state_d = NORMAL;
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign split_active = (state_q == SPLIT);

`ifdef ISSUE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_stall_cnt <= 32'd0;
            split_cnt    <= 32'd0;
        end else begin
            if (lu_stall) begin
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            end
            if (state_q == NORMAL && state_d == SPLIT) begin
                split_cnt <= split_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_lu_stall;
    assign unused_lu_stall = lu_stall;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed plan cases, then randomized traffic.
module tb_issue_scheduler;

    localparam int REG_W = 5;
    localparam int LD_W  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             validD1, validD2;
    logic [REG_W-1:0] rs1D1, rs2D1, rdD1, rs1D2, rs2D2, rdD2;
    logic             reg_writeD1, memD1, memD2;
    logic [REG_W-1:0] rdE1, rdE2;
    logic             reg_writeE1, reg_writeE2;
    logic [LD_W-1:0]  mem_loadE1, mem_loadE2;
    logic             flushE;
    logic             issue1, issue2, stallD, bubbleE, split_active;
`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0]      lu_stall_cnt, split_cnt;
`endif

    // Clock / reset
    always #5 clk = ~clk;

    issue_scheduler #(.REG_W(REG_W), .LD_W(LD_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .validD1      (validD1),
        .validD2      (validD2),
        .rs1D1        (rs1D1),
        .rs2D1        (rs2D1),
        .rdD1         (rdD1),
        .rs1D2        (rs1D2),
        .rs2D2        (rs2D2),
        .rdD2         (rdD2),
        .reg_writeD1  (reg_writeD1),
        .memD1        (memD1),
        .memD2        (memD2),
        .rdE1         (rdE1),
        .rdE2         (rdE2),
        .reg_writeE1  (reg_writeE1),
        .reg_writeE2  (reg_writeE2),
        .mem_loadE1   (mem_loadE1),
        .mem_loadE2   (mem_loadE2),
        .flushE       (flushE),
        .issue1       (issue1),
        .issue2       (issue2),
        .stallD       (stallD),
        .bubbleE      (bubbleE),
`ifdef ISSUE_SCHED_PERF_EN
        .lu_stall_cnt (lu_stall_cnt),
        .split_cnt    (split_cnt),
`endif
        .split_active (split_active)
    );

    // Scoreboard state and reference model
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  exp_q[$];
    bit          model_pending = 1'b0;
    logic [31:0] model_lu_cnt = 32'd0;
    logic [31:0] model_split_cnt = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // True when a source pair reads a register that a load in E has not yet produced.
    function automatic bit waits_on_load(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        logic [REG_W-1:0] e_rd[2];
        logic             e_wr[2];
        logic [LD_W-1:0]  e_ld[2];
        bit               r = 1'b0;
        e_rd[0] = rdE1;        e_rd[1] = rdE2;
        e_wr[0] = reg_writeE1; e_wr[1] = reg_writeE2;
        e_ld[0] = mem_loadE1;  e_ld[1] = mem_loadE2;
        for (int k = 0; k < 2; k++) begin
            if (e_wr[k] && e_ld[k] != 0 && e_rd[k] != 0 && (a == e_rd[k] || b == e_rd[k]))
                r = 1'b1;
        end
        return r;
    endfunction

    // Driver tasks
    task automatic clear_inputs();
        reset = 1'b0; flushE = 1'b0;
        validD1 = 1'b0; validD2 = 1'b0;
        rs1D1 = '0; rs2D1 = '0; rdD1 = '0; rs1D2 = '0; rs2D2 = '0; rdD2 = '0;
        reg_writeD1 = 1'b0; memD1 = 1'b0; memD2 = 1'b0;
        clear_e();
    endtask

    task automatic clear_e();
        rdE1 = '0; rdE2 = '0; reg_writeE1 = 1'b0; reg_writeE2 = 1'b0;
        mem_loadE1 = '0; mem_loadE2 = '0;
    endtask

    task automatic random_inputs();
        reset       = ($urandom_range(0, 63) == 0);
        flushE      = ($urandom_range(0, 15) == 0);
        validD1     = ($urandom_range(0, 3) != 0);
        validD2     = ($urandom_range(0, 3) != 0);
        rs1D1       = REG_W'($urandom_range(0, 7));
        rs2D1       = REG_W'($urandom_range(0, 7));
        rdD1        = REG_W'($urandom_range(0, 7));
        rs1D2       = REG_W'($urandom_range(0, 7));
        rs2D2       = REG_W'($urandom_range(0, 7));
        rdD2        = REG_W'($urandom_range(0, 7));
        reg_writeD1 = $urandom_range(0, 1);
        memD1       = ($urandom_range(0, 3) == 0);
        memD2       = ($urandom_range(0, 3) == 0);
        rdE1        = REG_W'($urandom_range(0, 7));
        rdE2        = REG_W'($urandom_range(0, 7));
        reg_writeE1 = $urandom_range(0, 1);
        reg_writeE2 = $urandom_range(0, 1);
        mem_loadE1  = ($urandom_range(0, 2) == 0) ? LD_W'($urandom_range(1, 7)) : '0;
        mem_loadE2  = ($urandom_range(0, 2) == 0) ? LD_W'($urandom_range(1, 7)) : '0;
    endtask

    // One cycle: predict from the current inputs, compare, then advance the model at the edge.
    task automatic step(input string tag);
        bit         i1, i2, st, bb, nxt, lu_hit, split_hit;
        logic [4:0] e;
        #1;
        i1 = 0; i2 = 0; st = 0; bb = 1; nxt = model_pending; lu_hit = 0; split_hit = 0;
        if (reset || flushE) begin
            nxt = 1'b0;
        end else if (model_pending) begin
            if (waits_on_load(rs1D2, rs2D2)) begin
                st = 1; lu_hit = 1;
            end else begin
                i2 = 1; bb = 0; nxt = 1'b0;
            end
        end else if ((validD1 && waits_on_load(rs1D1, rs2D1)) ||
                     (validD2 && waits_on_load(rs1D2, rs2D2))) begin
            st = 1; lu_hit = 1;
        end else if ((validD2 && reg_writeD1 && rdD1 != 0 && (rs1D2 == rdD1 || rs2D2 == rdD1)) ||
                     (validD1 && validD2 && memD1 && memD2)) begin
            i1 = validD1; st = 1; bb = 0; nxt = 1'b1; split_hit = 1;
        end else begin
            i1 = validD1; i2 = validD2; bb = !(validD1 || validD2);
        end
        exp_q.push_back({i1, i2, st, bb, model_pending});
        e = exp_q.pop_front();
        check({tag, ".issue1"}, 32'(issue1), 32'(e[4]));
        check({tag, ".issue2"}, 32'(issue2), 32'(e[3]));
        check({tag, ".stallD"}, 32'(stallD), 32'(e[2]));
        check({tag, ".bubbleE"}, 32'(bubbleE), 32'(e[1]));
        check({tag, ".split_active"}, 32'(split_active), 32'(e[0]));
`ifdef ISSUE_SCHED_PERF_EN
        check({tag, ".lu_stall_cnt"}, lu_stall_cnt, model_lu_cnt);
        check({tag, ".split_cnt"}, split_cnt, model_split_cnt);
`endif
        @(posedge clk);
        model_pending = nxt;
        if (reset) begin
            model_lu_cnt = 32'd0;
            model_split_cnt = 32'd0;
        end else begin
            model_lu_cnt = model_lu_cnt + 32'(lu_hit);
            model_split_cnt = model_split_cnt + 32'(split_hit);
        end
        @(negedge clk);
    endtask

    task automatic set_dep_pair();
        validD1 = 1'b1; validD2 = 1'b1;
        rdD1 = 5'd3; reg_writeD1 = 1'b1; rs1D2 = 5'd3;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset");
        reset = 1'b0;

        // Independent ALU pair
        validD1 = 1; validD2 = 1; rdD1 = 5'd5; reg_writeD1 = 1; rs1D2 = 5'd6;
        step("indep");
        step("indep_again");

        // Load in E1 feeding slot 2
        clear_inputs();
        validD1 = 1; validD2 = 1; rs2D2 = 5'd7;
        rdE1 = 5'd7; mem_loadE1 = 3'b010; reg_writeE1 = 1;
        step("lu_c0");
        clear_e();
        step("lu_c1");

        // Pair dependency split; slot 1 (ALU) now in E
        clear_inputs();
        set_dep_pair();
        step("dep_c0");
        rdE1 = 5'd3; reg_writeE1 = 1;
        step("dep_c1");
        clear_inputs();
        step("dep_idle");

        // Split where slot 1 is a load
        set_dep_pair();
        step("ldsplit_c0");
        rdE1 = 5'd3; reg_writeE1 = 1; mem_loadE1 = 3'b001;
        step("ldsplit_c1");
        clear_e();
        step("ldsplit_c2");

        // Two memory ops without register dependency
        clear_inputs();
        validD1 = 1; validD2 = 1; memD1 = 1; memD2 = 1; rdD1 = 5'd5; reg_writeD1 = 1; rs1D2 = 5'd6;
        step("memc_c0");
        step("memc_c1");

        // Load targeting x0 never stalls
        clear_inputs();
        validD1 = 1; rs1D1 = 5'd0; rdE1 = 5'd0; mem_loadE1 = 3'b010; reg_writeE1 = 1;
        step("x0_load");

        // Flush while slot 2 pending
        clear_inputs();
        set_dep_pair();
        step("flush_c0");
        flushE = 1;
        step("flush_c1");
        clear_inputs();
        step("flush_c2");

        // Reset in the middle of a split
        set_dep_pair();
        step("rst_c0");
        reset = 1;
        step("rst_c1");
        reset = 0;
        clear_inputs();
        step("rst_c2");

        for (int n = 0; n < 600; n++) begin
            random_inputs();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
